mux8_rr_scheduler: RTL and testbench
====================================

# mux8_rr_scheduler

Round-robin scheduler that shares the 8:1 multiplexer datapath among eight requesters. It arbitrates a one-hot request vector and drives the mux's three select lines (sel1 = LSB, sel3 = MSB) plus a one-hot grant. Each owner keeps the mux for a bounded burst, then ownership rotates. It sits directly in front of the 8:1 mux tree.

## Interface

- BURST, default 4: maximum consecutive cycles an owner holds the mux while another requester waits (legal 1..15).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req  input  8  request per mux input; bit k corresponds to mux input ik.
- gnt  output  8  one-hot grant, registered; all zero when idle.
- sel1  output  1  mux select bit 0 (first 2:1 stage), registered.
- sel2  output  1  mux select bit 1 (second stage), registered.
- sel3  output  1  mux select bit 2 (final stage), registered.
- valid  output  1  high when gnt is non-zero and {sel3,sel2,sel1} addresses the owner.

## Operation

- Internal state: FSM {IDLE, GRANT}, 3-bit owner, 3-bit rotation pointer ptr, 4-bit burst counter cnt.
- Pick function: the lowest index at or after ptr, wrapping 7→0, among candidate requests. Only ptr sets priority; index order is used only as the wrap direction.
- IDLE:
  - If req==0, stay in IDLE.
  - Else grant pick(req, ptr): owner = picked index, cnt = 1, go to GRANT.
- GRANT, with owner o:
  - req[o]==0 (release): set ptr = o+1 mod 8 and pick among req. On a hit, grant the new owner with cnt = 1. On no hit, go to IDLE: gnt = 0, valid = 0, sel holds its last value.
  - req[o]==1, cnt==BURST, and another request is pending (req with bit o masked is non-zero): set ptr = o+1 mod 8 and grant pick(req with bit o masked, ptr) with cnt = 1 (forced rotation).
  - Otherwise hold the owner; cnt increments and saturates at BURST. A lone requester keeps the mux indefinitely.
- Outputs always satisfy {sel3,sel2,sel1} == owner, gnt == 1<<owner, and valid == |gnt.
- Requests are level signals. No request is dropped: a waiting requester is granted within 7×BURST cycles plus release latency.

## Timing

- Reset value of every output: gnt = 8'h00, sel1 = sel2 = sel3 = 0, valid = 0. Internal reset: ptr = 0, cnt = 0, state IDLE. Reset asserted mid-burst clears everything immediately, without waiting for a clock edge.
- First reset-release edge: req sampled, gnt/valid appear on the following edge.
- Grant latency: 1 cycle from req rising (sampled at edge N) to gnt/sel valid after edge N.
- Handover is zero-bubble. On a release or forced rotation at edge N, the new owner is driven after edge N; valid never drops between owners.
- Release latency: deassert req[o] before edge N, and gnt[o] is low after edge N.
- Simultaneous release by the owner and a new request from index o+1: the new requester is granted at the same edge.
- sel changes only on edges where gnt changes to a new non-zero owner. The mux output is therefore glitch-free relative to clk.

## Structure

- Shared package mux8_pkg holds:
  - NUM_REQ = 8 and SEL_W = 3;
  - the state enum {IDLE, GRANT};
  - the function mapping a 3-bit index to {sel3,sel2,sel1}.
- Sub-module rr_pick8: purely combinational. Inputs are an 8-bit candidate vector and a 3-bit ptr; outputs are hit and a 3-bit index. It is instantiated once; the candidate vector is muxed between req and req with the owner masked.
- Top level holds the FSM, owner, ptr and cnt registers, and output decode.

## Test plan

- Reset: hold rst_n=0 with req=8'hFF, then pulse rst_n low again mid-burst → gnt=0, valid=0, sel=000 asynchronously, both times.
- Single request: req=8'h20 → one edge later gnt=8'h20, {sel3,sel2,sel1}=101, valid=1. It is held for 20 cycles with BURST=4, since no other requester is pending.
- Rotation: req=8'h81 held constant, BURST=4 → gnt alternates 8'h01 for 4 cycles, then 8'h80 for 4 cycles, repeating. sel alternates 000/111 with no valid gap.
- Release handover: owner 3, req changes 8'h08→8'h14 at one edge → next gnt=8'h10 (index 4, first after ptr=4), not 8'h04.
- Wrap-around: owner 7 releases while req=8'h06 → gnt=8'h02 (ptr wraps to 0, then picks index 1).
- Idle return: the sole owner drops its request → gnt=0, valid=0, sel keeps its previous value. A new req=8'h01 is granted one edge later.

Source files
------------

// File: rtl/mux8_pkg.sv
// Shared types and helpers for the 8-requester round-robin mux scheduler.
package mux8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Select lines are a straight binary encoding of the owner: {sel3,sel2,sel1}.
  function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] idx);
    return idx;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: lowest candidate index at or after ptr, wrapping 7->0.
module rr_pick8
  import mux8_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [SEL_W-1:0]   ptr,
  output logic               hit,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] k;

  // Scan from the farthest offset back to ptr so the nearest candidate wins last.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    hit = 1'b0;
    idx = ptr;
    k   = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (cand[k]) begin
        hit = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner scheduler driving the select lines of an 8:1 mux tree, with bounded bursts.
module mux8_rr_scheduler
  import mux8_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   req,
  output logic [7:0]   gnt,
  output logic         sel1,
  output logic         sel2,
  output logic         sel3,
  output logic         valid
);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic               valid_q;

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] cand;
  logic [SEL_W-1:0]   next_idx;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_hit;
  logic               in_grant;
  logic               release_own;
  logic               rotate;

  assign in_grant    = (state_q == GRANT);
  assign next_idx    = owner_q + SEL_W'(1);
  assign masked      = req & ~idx_to_onehot(owner_q);
  assign release_own = in_grant && !req[owner_q];
  assign rotate      = in_grant && req[owner_q] && (cnt_q == BURST_C) && (|masked);

  // A single picker serves both paths; only a forced rotation hides the current owner.
  assign cand     = rotate ? masked : req;
  assign pick_ptr = in_grant ? next_idx : ptr_q;

  rr_pick8 u_pick (
    .cand (cand),
    .ptr  (pick_ptr),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          state_d = GRANT;
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_own) begin
          ptr_d = next_idx;
          if (pick_hit) begin
            owner_d = pick_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            // Owner is kept so the select lines hold their last value while idle.
            state_d = IDLE;
          end
        end else if (rotate) begin
          ptr_d   = next_idx;
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q != BURST_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= (state_d == GRANT) ? idx_to_onehot(owner_d) : '0;
      valid_q <= (state_d == GRANT);
    end
  end

  assign gnt                = gnt_q;
  assign valid              = valid_q;
  assign {sel3, sel2, sel1} = idx_to_sel(owner_q);

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed self-checking bench for mux8_rr_scheduler with BURST=4.
module tb_mux8_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       sel1;
  logic       sel2;
  logic       sel3;
  logic       valid;

  int total = 0;
  int bad   = 0;

  mux8_rr_scheduler #(.BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel1  (sel1),
    .sel2  (sel2),
    .sel3  (sel3),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_gnt,
                           input logic [2:0] exp_sel, input logic exp_valid);
    check({tag, "_gnt"}, gnt, exp_gnt);
    check({tag, "_sel"}, {5'b0, sel3, sel2, sel1}, {5'b0, exp_sel});
    check({tag, "_valid"}, {7'b0, valid}, {7'b0, exp_valid});
  endtask

  initial begin
    logic [7:0] exp_g;
    logic [2:0] exp_s;

    // Reset held with all requests asserted.
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_out("rst_hold", 8'h00, 3'b000, 1'b0);

    rst_n = 1'b1;
    tick();
    check_out("first_grant", 8'h01, 3'b000, 1'b1);
    tick();
    check_out("burst_hold", 8'h01, 3'b000, 1'b1);

    // Asynchronous reset mid-burst, observed before the next edge.
    #2 rst_n = 1'b0;
    #1;
    check_out("rst_async1", 8'h00, 3'b000, 1'b0);
    rst_n = 1'b1;
    req   = 8'h20;

    // Single requester keeps the mux well beyond BURST.
    tick();
    check_out("single", 8'h20, 3'b101, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("single_hold_gnt", gnt, 8'h20);
    end

    // Idle return: sel keeps 101; ptr moves to 6, so req 01 wraps to index 0.
    req = 8'h00;
    tick();
    check_out("idle", 8'h00, 3'b101, 1'b0);
    req = 8'h01;
    tick();
    check_out("idle_regrant", 8'h01, 3'b000, 1'b1);
    req = 8'h00;
    tick();
    check_out("idle2", 8'h00, 3'b000, 1'b0);

    // Rotation between 7 and 0; ptr is 1 here, so index 7 is picked first.
    req = 8'h81;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_g = (((k / 4) % 2) == 0) ? 8'h80 : 8'h01;
      exp_s = (((k / 4) % 2) == 0) ? 3'b111 : 3'b000;
      check_out("rotate", exp_g, exp_s, 1'b1);
    end

    // Owner 0 releases, index 3 takes over with no bubble.
    req = 8'h08;
    tick();
    check_out("to_owner3", 8'h08, 3'b011, 1'b1);

    // Release handover: ptr=4 picks index 4 ahead of index 2.
    req = 8'h14;
    tick();
    check_out("release_ho", 8'h10, 3'b100, 1'b1);

    req = 8'h80;
    tick();
    check_out("to_owner7", 8'h80, 3'b111, 1'b1);

    // Wrap-around: ptr wraps to 0, first candidate is index 1.
    req = 8'h06;
    tick();
    check_out("wrap", 8'h02, 3'b001, 1'b1);

    // Owner 1 drops while index 2 rises at the same edge.
    req = 8'h04;
    tick();
    check_out("simul_rel", 8'h04, 3'b010, 1'b1);

    // Forced rotation after the owner's fourth cycle.
    req = 8'h05;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("force_hold", 8'h04, 3'b010, 1'b1);
    end
    tick();
    check_out("force_rot", 8'h01, 3'b000, 1'b1);
    tick();
    check_out("force_new", 8'h01, 3'b000, 1'b1);

    // Second asynchronous reset mid-burst with a non-zero select.
    req = 8'h04;
    tick();
    tick();
    check_out("pre_rst2", 8'h04, 3'b010, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_out("rst_async2", 8'h00, 3'b000, 1'b0);
    tick();
    check_out("rst_hold2", 8'h00, 3'b000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
